pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MDU_MAX_CYCLES, default 70, max cycles waited for mdu_done before timeout.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; 0 = reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_rs1, id_rs2  in  5 each  ID source register indices.
REQ-006 id_rs1_used, id_rs2_used  in  1 each  ID instruction reads rs1/rs2.
REQ-007 id_is_mdu  in  1  ID instruction is an M-extension mul/div op.
REQ-008 ex_rd, mem_rd  in  5 each  destination register in EX/MEM.
REQ-009 ex_wen, mem_wen  in  1 each  EX/MEM instruction writes regfile.
REQ-010 ex_is_load  in  1  EX instruction is a load.
REQ-011 ex_branch_taken  in  1  EX resolved a taken branch/jump.
REQ-012 ex_exit  in  1  EX instruction is the exit/ebreak.
REQ-013 mdu_done  in  1  MDU result valid, one-cycle pulse.
REQ-014 stall_if, stall_id  out  1 each  hold PC / hold IF-ID register.
REQ-015 flush_id, bubble_ex  out  1 each  clear IF-ID / insert NOP into ID-EX.
REQ-016 fwd_a_sel, fwd_b_sel  out  2 each  operand source: 00 regfile, 01 EX, 10 MEM.
REQ-017 mdu_start, mdu_abort  out  1 each  one-cycle MDU command pulses.
REQ-018 halted  out  1  core stopped by exit.
REQ-019 err_timeout  out  1  sticky MDU timeout flag.
REQ-020 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-021 FSM states RUN, MDU_WAIT, HALT; wait counter 7 bits.
REQ-022 Forwarding combinational: fwd_a_sel=01 if ex_wen, ex_rd!=0, ex_rd==id_rs1, !ex_is_load; else 10 if mem_wen, mem_rd!=0, mem_rd==id_rs1; else 00; fwd_b_sel identical on id_rs2; EX beats MEM.
REQ-023 Load-use (RUN): id_valid, ex_is_load, ex_wen, ex_rd!=0, ex_rd matches a used source -> stall_if=stall_id=bubble_ex=1 that cycle only; next cycle MEM forwarding resolves it.
REQ-024 MDU issue (RUN): id_valid, id_is_mdu, no load-use, no branch, no exit -> mdu_start=1 one cycle, counter cleared, next state MDU_WAIT.
REQ-025 MDU_WAIT: stall_if=stall_id=bubble_ex=1, counter +1 per cycle; on mdu_done: all three 0 that cycle (ID advances, EX captures result), next state RUN.
REQ-026 Counter reaching MDU_MAX_CYCLES without mdu_done -> err_timeout=1, mdu_abort=1 one cycle, next state HALT.
REQ-027 ex_branch_taken in RUN or MDU_WAIT -> flush_id=bubble_ex=1, stall_if=stall_id=0, load-use and MDU issue suppressed; in MDU_WAIT also mdu_abort=1, next state RUN.
REQ-028 mdu_done coincident with ex_branch_taken: branch wins, result discarded, mdu_abort=1.
REQ-029 ex_exit in RUN or MDU_WAIT -> next state HALT; exit beats branch and mdu_done; mdu_abort=1 if in MDU_WAIT.
REQ-030 HALT: stall_if=stall_id=bubble_ex=1, halted=1, flush_id=0; no exit except reset.
REQ-031 stall_cnt +1 each cycle stall_if=1 and state!=HALT; saturates at 0xFFFF_FFFF.
REQ-032 mdu_start never asserted outside RUN; mdu_start and mdu_abort never both 1.

Reset
REQ-033 reset=0 at clock edge: state RUN, counter 0, err_timeout 0, stall_cnt 0, halted 0.
REQ-034 During reset all command outputs 0: stall_if, stall_id, flush_id, bubble_ex, mdu_start, mdu_abort; fwd_*_sel 00.
REQ-035 Reset mid-MDU_WAIT returns to RUN without mdu_abort pulse; MDU reset separately.

Structure
REQ-036 Shared package pipe_ctrl_pkg: state enum, fwd_sel constants (FWD_RF, FWD_EX, FWD_MEM), MDU_MAX_CYCLES default.
REQ-037 One combinational sub-module fwd_unit computes fwd_a_sel/fwd_b_sel; FSM, counters, hazard logic in pipe_ctrl.

Verification
REQ-038 ex_rd=5, ex_wen=1, id_rs1=5 used, ex_is_load=0 -> fwd_a_sel=01; same with mem_rd=5 only -> 10; rd=0 -> 00.
REQ-039 ex_is_load=1, ex_rd=7, id_rs2=7 used -> one cycle stall_if=stall_id=bubble_ex=1, next cycle 0, stall_cnt=1.
REQ-040 id_is_mdu issue, mdu_done after 10 cycles -> mdu_start single pulse, stall 10 cycles, released on done cycle, state RUN.
REQ-041 ex_branch_taken in 3rd MDU_WAIT cycle -> flush_id=1, mdu_abort=1, state RUN; later mdu_done ignored.
REQ-042 No mdu_done for 70 cycles -> err_timeout=1, mdu_abort pulse, halted=1; reset=0 one edge -> all cleared.
REQ-043 ex_exit and ex_branch_taken same cycle -> HALT, halted=1, held until reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, operand-forward select codes and MDU wait limits.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int MDU_MAX_CYCLES_DEF = 70;
    localparam int WAIT_CNT_W         = 7;

    // EX has the younger value, so it takes priority over MEM.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EX;
        end else if (mem_hit) begin
            return FWD_MEM;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// Combinational operand-forward selection for both ID source operands.
// A load in EX cannot forward; its data arrives one stage later via MEM.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_wen,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_wen,
    output logic [1:0] o_fwd_a_sel,
    output logic [1:0] o_fwd_b_sel
);

    logic w_ex_ok;
    logic w_mem_ok;

    assign w_ex_ok  = i_ex_wen && (i_ex_rd != 5'd0) && !i_ex_is_load;
    assign w_mem_ok = i_mem_wen && (i_mem_rd != 5'd0);

    assign o_fwd_a_sel = fwd_pick(w_ex_ok && (i_ex_rd == i_id_rs1),
                                  w_mem_ok && (i_mem_rd == i_id_rs1));
    assign o_fwd_b_sel = fwd_pick(w_ex_ok && (i_ex_rd == i_id_rs2),
                                  w_mem_ok && (i_mem_rd == i_id_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, MDU issue/wait with
// timeout, exit halt, and a saturating stall-cycle counter.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_RUN      | normal flow; detects load-use, branch, MDU issue, exit
// ST_MDU_WAIT | front end frozen until mdu_done, branch, exit or timeout
// ST_HALT     | core stopped by exit or MDU timeout; left only by reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_MAX_CYCLES = MDU_MAX_CYCLES_DEF
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic        i_id_is_mdu,
    input  logic [4:0]  i_ex_rd,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_ex_wen,
    input  logic        i_mem_wen,
    input  logic        i_ex_is_load,
    input  logic        i_ex_branch_taken,
    input  logic        i_ex_exit,
    input  logic        i_mdu_done,
    output logic        o_stall_if,
    output logic        o_stall_id,
    output logic        o_flush_id,
    output logic        o_bubble_ex,
    output logic [1:0]  o_fwd_a_sel,
    output logic [1:0]  o_fwd_b_sel,
    output logic        o_mdu_start,
    output logic        o_mdu_abort,
    output logic        o_halted,
    output logic        o_err_timeout,
    output logic [31:0] o_stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0] LP_CNT_LAST = WAIT_CNT_W'(MDU_MAX_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_err_timeout;
    logic [31:0]           r_stall_cnt;
    logic                  w_timeout;
    logic                  w_load_use;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;

    fwd_unit u_fwd (
        .i_id_rs1     (i_id_rs1),
        .i_id_rs2     (i_id_rs2),
        .i_ex_rd      (i_ex_rd),
        .i_ex_wen     (i_ex_wen),
        .i_ex_is_load (i_ex_is_load),
        .i_mem_rd     (i_mem_rd),
        .i_mem_wen    (i_mem_wen),
        .o_fwd_a_sel  (w_fwd_a),
        .o_fwd_b_sel  (w_fwd_b)
    );

    assign w_load_use = i_id_valid && i_ex_is_load && i_ex_wen && (i_ex_rd != 5'd0) &&
                        ((i_id_rs1_used && (i_ex_rd == i_id_rs1)) ||
                         (i_id_rs2_used && (i_ex_rd == i_id_rs2)));

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        o_stall_if   = 1'b0;
        o_stall_id   = 1'b0;
        o_flush_id   = 1'b0;
        o_bubble_ex  = 1'b0;
        o_mdu_start  = 1'b0;
        o_mdu_abort  = 1'b0;
        o_fwd_a_sel  = w_fwd_a;
        o_fwd_b_sel  = w_fwd_b;

        case (r_state)
            ST_RUN: begin
                if (i_ex_exit) begin
                    w_state_next = ST_HALT;
                    o_stall_if   = 1'b1;
                    o_stall_id   = 1'b1;
                    o_bubble_ex  = 1'b1;
                end else if (i_ex_branch_taken) begin
                    o_flush_id  = 1'b1;
                    o_bubble_ex = 1'b1;
                end else if (w_load_use) begin
                    o_stall_if  = 1'b1;
                    o_stall_id  = 1'b1;
                    o_bubble_ex = 1'b1;
                end else if (i_id_valid && i_id_is_mdu) begin
                    o_mdu_start  = 1'b1;
                    w_state_next = ST_MDU_WAIT;
                end
            end
            ST_MDU_WAIT: begin
                if (i_ex_exit) begin
                    w_state_next = ST_HALT;
                    o_mdu_abort  = 1'b1;
                    o_stall_if   = 1'b1;
                    o_stall_id   = 1'b1;
                    o_bubble_ex  = 1'b1;
                end else if (i_ex_branch_taken) begin
                    w_state_next = ST_RUN;
                    o_mdu_abort  = 1'b1;
                    o_flush_id   = 1'b1;
                    o_bubble_ex  = 1'b1;
                end else if (i_mdu_done) begin
                    w_state_next = ST_RUN;
                end else begin
                    o_stall_if  = 1'b1;
                    o_stall_id  = 1'b1;
                    o_bubble_ex = 1'b1;
                    if (r_wait_cnt == LP_CNT_LAST) begin
                        w_timeout    = 1'b1;
                        o_mdu_abort  = 1'b1;
                        w_state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_bubble_ex = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // Commands are held quiet while reset is asserted.
        if (!i_reset) begin
            w_timeout   = 1'b0;
            o_stall_if  = 1'b0;
            o_stall_id  = 1'b0;
            o_flush_id  = 1'b0;
            o_bubble_ex = 1'b0;
            o_mdu_start = 1'b0;
            o_mdu_abort = 1'b0;
            o_fwd_a_sel = FWD_RF;
            o_fwd_b_sel = FWD_RF;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (o_mdu_start) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_MDU_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
            if (o_stall_if && (r_state != ST_HALT) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_halted      = (r_state == ST_HALT);
    assign o_err_timeout = r_err_timeout;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of RUN-state hazard/forwarding vectors
// followed by hand-written multi-cycle MDU, branch, timeout and exit sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, rs1_used, rs2_used, id_is_mdu;
    logic [4:0]  rs1, rs2, ex_rd, mem_rd;
    logic        ex_wen, mem_wen, ex_is_load, br_taken, ex_exit, mdu_done;
    logic        stall_if, stall_id, flush_id, bubble_ex, mdu_start, mdu_abort;
    logic        halted, err_timeout;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MDU_MAX_CYCLES(70)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_id_valid        (id_valid),
        .i_id_rs1          (rs1),
        .i_id_rs2          (rs2),
        .i_id_rs1_used     (rs1_used),
        .i_id_rs2_used     (rs2_used),
        .i_id_is_mdu       (id_is_mdu),
        .i_ex_rd           (ex_rd),
        .i_mem_rd          (mem_rd),
        .i_ex_wen          (ex_wen),
        .i_mem_wen         (mem_wen),
        .i_ex_is_load      (ex_is_load),
        .i_ex_branch_taken (br_taken),
        .i_ex_exit         (ex_exit),
        .i_mdu_done        (mdu_done),
        .o_stall_if        (stall_if),
        .o_stall_id        (stall_id),
        .o_flush_id        (flush_id),
        .o_bubble_ex       (bubble_ex),
        .o_fwd_a_sel       (fwd_a),
        .o_fwd_b_sel       (fwd_b),
        .o_mdu_start       (mdu_start),
        .o_mdu_abort       (mdu_abort),
        .o_halted          (halted),
        .o_err_timeout     (err_timeout),
        .o_stall_cnt       (stall_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic [4:0] exrd;
        logic       exw;
        logic       exld;
        logic [4:0] memrd;
        logic       memw;
        logic       br;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       stall;
        logic       flush;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        id_is_mdu = 1'b0; ex_rd = 5'd0; mem_rd = 5'd0; ex_wen = 1'b0; mem_wen = 1'b0;
        ex_is_load = 1'b0; br_taken = 1'b0; ex_exit = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        adv();
        rst = 1'b1;
    endtask

    // RUN-state MDU issue followed by the given number of plain wait cycles.
    task automatic issue_and_wait(input int n_wait, input string tag);
        id_valid = 1'b1; id_is_mdu = 1'b1;
        settle();
        chk({tag, "_start"}, {31'd0, mdu_start}, 32'd1);
        chk({tag, "_issue_nostall"}, {31'd0, stall_if}, 32'd0);
        adv();
        for (int k = 0; k < n_wait; k++) begin
            settle();
            chk({tag, "_wait_stall"}, {29'd0, stall_if, stall_id, bubble_ex}, 32'd7);
            chk({tag, "_wait_cmds"}, {30'd0, mdu_start, mdu_abort}, 32'd0);
            adv();
        end
    endtask

    initial begin
        int exp_cnt;
        vt[0]  = '{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 5'd3,  5'd9,  1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 5'd1,  5'd7,  1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 5'd7,  5'd7,  1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 5'd2,  5'd7,  1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1};
        vt[10] = '{1'b1, 5'd6,  5'd6,  1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        vt[11] = '{1'b1, 5'd8,  5'd8,  1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0};

        // Reset with a forwarding/load-use pattern present: commands must stay quiet.
        idle_inputs();
        rst = 1'b0;
        #1;
        id_valid = 1'b1; rs1 = 5'd5; rs1_used = 1'b1; ex_rd = 5'd5; ex_wen = 1'b1; ex_is_load = 1'b1;
        adv();
        adv();
        settle();
        chk("rst_cmds", {26'd0, stall_if, stall_id, flush_id, bubble_ex, mdu_start, mdu_abort}, 32'd0);
        chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        adv();
        rst = 1'b1;
        idle_inputs();
        settle();
        chk("rst_state", {30'd0, halted, err_timeout}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);

        // Table of single-cycle RUN vectors.
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            id_valid = vt[i].v; rs1 = vt[i].r1; rs2 = vt[i].r2;
            rs1_used = vt[i].u1; rs2_used = vt[i].u2;
            ex_rd = vt[i].exrd; ex_wen = vt[i].exw; ex_is_load = vt[i].exld;
            mem_rd = vt[i].memrd; mem_wen = vt[i].memw; br_taken = vt[i].br;
            settle();
            chk($sformatf("vec%0d_fwd", i), {28'd0, fwd_a, fwd_b}, {28'd0, vt[i].fa, vt[i].fb});
            chk($sformatf("vec%0d_ctl", i), {28'd0, stall_if, stall_id, bubble_ex, flush_id},
                {28'd0, vt[i].stall, vt[i].stall, vt[i].stall | vt[i].flush, vt[i].flush});
            chk($sformatf("vec%0d_mdu", i), {30'd0, mdu_start, mdu_abort}, 32'd0);
            adv();
            if (vt[i].stall) exp_cnt++;
            settle();
            chk($sformatf("vec%0d_cnt", i), stall_cnt, exp_cnt);
        end

        // Load-use on rs2 for one cycle, then MEM forwarding resolves it.
        do_reset();
        id_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd7; rs1_used = 1'b1; rs2_used = 1'b1;
        ex_rd = 5'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
        settle();
        chk("lu_stall", {29'd0, stall_if, stall_id, bubble_ex}, 32'd7);
        adv();
        ex_rd = 5'd3; ex_is_load = 1'b0; mem_rd = 5'd7; mem_wen = 1'b1;
        settle();
        chk("lu_release", {29'd0, stall_if, stall_id, bubble_ex}, 32'd0);
        chk("lu_fwd_b", {30'd0, fwd_b}, 32'd2);
        chk("lu_cnt", stall_cnt, 32'd1);

        // MDU: 10 stalled wait cycles, released on the done cycle.
        do_reset();
        issue_and_wait(10, "mdu");
        mdu_done = 1'b1;
        settle();
        chk("mdu_done_release", {26'd0, stall_if, stall_id, bubble_ex, flush_id, mdu_start, mdu_abort}, 32'd0);
        adv();
        mdu_done = 1'b0;
        settle();
        chk("mdu_cnt", stall_cnt, 32'd10);
        chk("mdu_back_run", {30'd0, mdu_start, stall_if}, 32'd2);

        // Branch in the third wait cycle aborts the MDU; a late done is ignored.
        do_reset();
        issue_and_wait(2, "br");
        br_taken = 1'b1;
        settle();
        chk("br_abort", {27'd0, stall_if, stall_id, flush_id, bubble_ex, mdu_abort}, 32'd7);
        chk("br_nostart", {31'd0, mdu_start}, 32'd0);
        adv();
        br_taken = 1'b0; id_is_mdu = 1'b0; mdu_done = 1'b1;
        settle();
        chk("br_late_done", {29'd0, stall_if, mdu_abort, mdu_start}, 32'd0);
        adv();
        mdu_done = 1'b0;
        settle();
        chk("br_cnt", stall_cnt, 32'd2);
        chk("br_state", {30'd0, halted, err_timeout}, 32'd0);

        // Done on the last allowed wait cycle must not time out.
        do_reset();
        issue_and_wait(69, "edge");
        mdu_done = 1'b1;
        settle();
        chk("edge_done", {29'd0, stall_if, mdu_abort, mdu_start}, 32'd0);
        adv();
        mdu_done = 1'b0; id_is_mdu = 1'b0;
        settle();
        chk("edge_state", {30'd0, halted, err_timeout}, 32'd0);

        // Timeout after 70 wait cycles, then reset clears everything.
        do_reset();
        issue_and_wait(69, "to");
        settle();
        chk("to_abort", {29'd0, stall_if, mdu_abort, mdu_start}, 32'd6);
        chk("to_not_yet", {31'd0, err_timeout}, 32'd0);
        adv();
        id_is_mdu = 1'b0;
        settle();
        chk("to_flags", {30'd0, halted, err_timeout}, 32'd3);
        chk("to_halt_out", {27'd0, stall_if, stall_id, bubble_ex, flush_id, mdu_abort}, 32'd28);
        chk("to_cnt", stall_cnt, 32'd70);
        adv();
        rst = 1'b0;
        settle();
        chk("to_rst_cmds", {29'd0, stall_if, bubble_ex, mdu_abort}, 32'd0);
        adv();
        rst = 1'b1;
        settle();
        chk("to_rst_clr", {30'd0, halted, err_timeout}, 32'd0);
        chk("to_rst_cnt", stall_cnt, 32'd0);

        // Exit beats a same-cycle branch; HALT holds and stops counting.
        do_reset();
        id_valid = 1'b1; ex_exit = 1'b1; br_taken = 1'b1;
        settle();
        chk("ex_noflush", {30'd0, flush_id, stall_if}, 32'd1);
        adv();
        ex_exit = 1'b0; br_taken = 1'b0; id_is_mdu = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("ex_halted", {28'd0, halted, stall_if, mdu_start, flush_id}, 32'd12);
            adv();
        end
        settle();
        chk("ex_cnt", stall_cnt, 32'd1);

        // Exit during MDU_WAIT with a coincident done: abort and halt.
        do_reset();
        issue_and_wait(3, "exw");
        ex_exit = 1'b1; mdu_done = 1'b1;
        settle();
        chk("exw_abort", {30'd0, mdu_abort, mdu_start}, 32'd2);
        adv();
        idle_inputs();
        settle();
        chk("exw_halted", {31'd0, halted}, 32'd1);

        // Reset mid-wait: no abort pulse, back in RUN afterwards.
        do_reset();
        issue_and_wait(4, "rw");
        rst = 1'b0;
        settle();
        chk("rw_noabort", {30'd0, mdu_abort, mdu_start}, 32'd0);
        adv();
        rst = 1'b1;
        settle();
        chk("rw_run", {30'd0, mdu_start, stall_if}, 32'd2);
        adv();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
